// File: rtl/memory_unit.sv
// memory_unit: memory (M) stage of a 5-stage RV32IM pipeline.
//
// Purpose:
//   - drives byte-lane write strobes and data for stores (combinational)
//   - extracts and sign/zero-extends load data from the word fetched in execute
//   - returns read-only cycle/instret counter values for CSRRS reads
//   - registers everything into the MW pipeline register
//
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   M_stall_i             hold the MW register and suppress the store
//   W_flush_i             squash the instruction entering MW
//   EM_*                  execute/memory pipeline register contents
//   DMemWAddr_o           word-aligned store address
//   DMemWData_o           lane-replicated store data
//   DMemWMask_o           byte write strobes (zero when no valid store)
//   misaligned_o          combinational misaligned-access flag
//   MW_*                  memory/writeback pipeline register contents
module memory_unit #(
  parameter logic [31:0] NOP_INSTR = 32'h00000033,
  parameter int          COUNTER_W = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        M_stall_i,
  input  logic        W_flush_i,
  input  logic [31:0] EM_PC_i,
  input  logic [31:0] EM_instr_i,
  input  logic        EM_nop_i,
  input  logic        EM_isLoad_i,
  input  logic        EM_isStore_i,
  input  logic        EM_isCSR_i,
  input  logic [4:0]  EM_rdId_i,
  input  logic [11:0] EM_csrId_i,
  input  logic [31:0] EM_rs2_i,
  input  logic [2:0]  EM_funct3_i,
  input  logic [31:0] EM_Eresult_i,
  input  logic [31:0] EM_addr_i,
  input  logic [31:0] EM_Mdata_i,
  input  logic        EM_wbEnable_i,
  output logic [31:0] DMemWAddr_o,
  output logic [31:0] DMemWData_o,
  output logic [3:0]  DMemWMask_o,
  output logic        misaligned_o,
  output logic [31:0] MW_PC_o,
  output logic [31:0] MW_instr_o,
  output logic        MW_nop_o,
  output logic        MW_wbEnable_o,
  output logic [4:0]  MW_rdId_o,
  output logic [31:0] MW_wbData_o
);

  localparam logic [COUNTER_W-1:0] CNT_ONE = COUNTER_W'(1);

  logic                 mem_op_s;
  logic                 is_half_s;
  logic                 is_word_s;
  logic                 misaligned_s;
  logic                 store_valid_s;
  logic [31:0]          store_data_s;
  logic [3:0]           store_mask_s;
  logic [31:0]          load_data_s;
  logic [31:0]          csr_data_s;
  logic [31:0]          wb_data_s;
  logic [COUNTER_W-1:0] cycle_r;
  logic [COUNTER_W-1:0] instret_r;
  logic [63:0]          cycle_ext_s;
  logic [63:0]          instret_ext_s;

  // Lane extraction for loads; funct3 encodings outside the RV32I load set return 0.
  function automatic logic [31:0] extract_load(input logic [2:0]  f3,
                                               input logic [1:0]  lo,
                                               input logic [31:0] word);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    byte_v = 8'(word >> {lo, 3'b000});
    half_v = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extract_load = {{24{byte_v[7]}}, byte_v};
      3'b001:  extract_load = {{16{half_v[15]}}, half_v};
      3'b010:  extract_load = word;
      3'b100:  extract_load = {24'h000000, byte_v};
      3'b101:  extract_load = {16'h0000, half_v};
      default: extract_load = 32'h00000000;
    endcase
  endfunction

  assign cycle_ext_s   = 64'(cycle_r);
  assign instret_ext_s = 64'(instret_r);

  // Misalignment is judged on the access size alone; bubbles never flag.
  always_comb begin
    mem_op_s  = (EM_isLoad_i | EM_isStore_i) & ~EM_nop_i;
    is_half_s = (EM_funct3_i[1:0] == 2'b01);
    is_word_s = (EM_funct3_i[1:0] == 2'b10);
    if (mem_op_s) begin
      misaligned_s = (is_half_s & EM_addr_i[0]) |
                     (is_word_s & (EM_addr_i[1:0] != 2'b00));
    end else begin
      misaligned_s = 1'b0;
    end
  end

  // Store data replication and byte strobes; a stalled or misaligned store writes nothing.
  always_comb begin
    store_valid_s = EM_isStore_i & ~EM_nop_i & ~M_stall_i & ~misaligned_s;
    store_data_s  = EM_rs2_i;
    store_mask_s  = 4'b0000;
    case (EM_funct3_i[1:0])
      2'b00: begin
        store_data_s = {4{EM_rs2_i[7:0]}};
        store_mask_s = 4'b0001 << EM_addr_i[1:0];
      end
      2'b01: begin
        store_data_s = {2{EM_rs2_i[15:0]}};
        store_mask_s = EM_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        store_data_s = EM_rs2_i;
        store_mask_s = 4'b1111;
      end
      default: begin
        store_data_s = EM_rs2_i;
        store_mask_s = 4'b0000;
      end
    endcase
  end

  assign DMemWAddr_o  = {EM_addr_i[31:2], 2'b00};
  assign DMemWData_o  = store_data_s;
  assign DMemWMask_o  = store_valid_s ? store_mask_s : 4'b0000;
  assign misaligned_o = misaligned_s;
  assign load_data_s  = extract_load(EM_funct3_i, EM_addr_i[1:0], EM_Mdata_i);

  // Counter CSR read (CSRRS x0 only); counters are observed before this cycle's increment.
  always_comb begin
    csr_data_s = 32'h00000000;
    if (EM_funct3_i == 3'b010) begin
      case (EM_csrId_i)
        12'hC00: csr_data_s = cycle_ext_s[31:0];
        12'hC80: csr_data_s = cycle_ext_s[63:32];
        12'hC02: csr_data_s = instret_ext_s[31:0];
        12'hC82: csr_data_s = instret_ext_s[63:32];
        default: csr_data_s = 32'h00000000;
      endcase
    end else begin
      csr_data_s = 32'h00000000;
    end
  end

  // Writeback source select: load, then CSR, then the execute result.
  always_comb begin
    wb_data_s = EM_Eresult_i;
    if (EM_isLoad_i) begin
      wb_data_s = load_data_s;
    end else if (EM_isCSR_i) begin
      wb_data_s = csr_data_s;
    end else begin
      wb_data_s = EM_Eresult_i;
    end
  end

  // MW pipeline register; flush overrides only the control fields, data follows stall.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      MW_PC_o       <= 32'h00000000;
      MW_instr_o    <= NOP_INSTR;
      MW_nop_o      <= 1'b1;
      MW_wbEnable_o <= 1'b0;
      MW_rdId_o     <= 5'd0;
      MW_wbData_o   <= 32'h00000000;
    end else begin
      if (!M_stall_i) begin
        MW_PC_o       <= EM_PC_i;
        MW_instr_o    <= EM_instr_i;
        MW_nop_o      <= EM_nop_i;
        MW_wbEnable_o <= EM_wbEnable_i & ~EM_nop_i;
        MW_rdId_o     <= EM_rdId_i;
        MW_wbData_o   <= wb_data_s;
      end
      if (W_flush_i) begin
        MW_instr_o    <= NOP_INSTR;
        MW_nop_o      <= 1'b1;
        MW_wbEnable_o <= 1'b0;
      end
    end
  end

  // Free-running cycle counter and retired-instruction counter, both wrapping.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cycle_r   <= '0;
      instret_r <= '0;
    end else begin
      cycle_r <= cycle_r + CNT_ONE;
      if (!M_stall_i && !EM_nop_i && !W_flush_i) begin
        instret_r <= instret_r + CNT_ONE;
      end else begin
        instret_r <= instret_r;
      end
    end
  end

endmodule

// File: tb/tb_memory_unit.sv
module tb_memory_unit;

  localparam logic [31:0] NOP = 32'h00000033;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        M_stall_i, W_flush_i, EM_nop_i, EM_isLoad_i, EM_isStore_i, EM_isCSR_i, EM_wbEnable_i;
  logic [31:0] EM_PC_i, EM_instr_i, EM_rs2_i, EM_Eresult_i, EM_addr_i, EM_Mdata_i;
  logic [4:0]  EM_rdId_i;
  logic [11:0] EM_csrId_i;
  logic [2:0]  EM_funct3_i;
  logic [31:0] DMemWAddr_o, DMemWData_o, MW_PC_o, MW_instr_o, MW_wbData_o;
  logic [3:0]  DMemWMask_o;
  logic        misaligned_o, MW_nop_o, MW_wbEnable_o;
  logic [4:0]  MW_rdId_o;

  memory_unit dut (
    .clk_i(clk_i), .reset_i(reset_i), .M_stall_i(M_stall_i), .W_flush_i(W_flush_i),
    .EM_PC_i(EM_PC_i), .EM_instr_i(EM_instr_i), .EM_nop_i(EM_nop_i),
    .EM_isLoad_i(EM_isLoad_i), .EM_isStore_i(EM_isStore_i), .EM_isCSR_i(EM_isCSR_i),
    .EM_rdId_i(EM_rdId_i), .EM_csrId_i(EM_csrId_i), .EM_rs2_i(EM_rs2_i),
    .EM_funct3_i(EM_funct3_i), .EM_Eresult_i(EM_Eresult_i), .EM_addr_i(EM_addr_i),
    .EM_Mdata_i(EM_Mdata_i), .EM_wbEnable_i(EM_wbEnable_i),
    .DMemWAddr_o(DMemWAddr_o), .DMemWData_o(DMemWData_o), .DMemWMask_o(DMemWMask_o),
    .misaligned_o(misaligned_o), .MW_PC_o(MW_PC_o), .MW_instr_o(MW_instr_o),
    .MW_nop_o(MW_nop_o), .MW_wbEnable_o(MW_wbEnable_o), .MW_rdId_o(MW_rdId_o),
    .MW_wbData_o(MW_wbData_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- reference model (ISA-level arithmetic) ----------------
  function automatic int unsigned f_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] md);
    int unsigned b, h, lo;
    lo = addr % 4;
    b  = (md >> (8 * lo)) & 32'hFF;
    h  = (lo >= 2) ? (md >> 16) : (md & 32'hFFFF);
    case (f3)
      3'd0:    return (b >= 128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32768) ? h - 32'h10000 : h;
      3'd2:    return md;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] f_csr(input logic [11:0] id, input logic [2:0] f3,
                                        input logic [63:0] cyc, input logic [63:0] ins);
    if (f3 != 3'd2) return 32'd0;
    case (id)
      12'hC00: return cyc[31:0];
      12'hC80: return cyc[63:32];
      12'hC02: return ins[31:0];
      12'hC82: return ins[63:32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] f_sdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (f_size(f3))
      1:       return (rs2 & 32'hFF) * 32'h01010101;
      2:       return (rs2 & 32'hFFFF) * 32'h00010001;
      default: return rs2;
    endcase
  endfunction

  logic        preload = 1'b0;
  logic [63:0] preload_val = 64'h00000000_FFFFFFFF;
  logic [31:0] m_pc, m_instr, m_data;
  logic        m_nop, m_wb;
  logic [4:0]  m_rd;
  logic [63:0] m_cycle, m_instret, cyc_now;
  logic [31:0] exp_wb;
  logic        exp_mis;
  logic [3:0]  exp_mask;

  assign cyc_now = preload ? preload_val : m_cycle;
  assign exp_wb  = EM_isLoad_i ? f_load(EM_funct3_i, EM_addr_i, EM_Mdata_i) :
                   EM_isCSR_i  ? f_csr(EM_csrId_i, EM_funct3_i, cyc_now, m_instret) :
                                 EM_Eresult_i;
  assign exp_mis = (EM_isLoad_i || EM_isStore_i) && !EM_nop_i && (f_size(EM_funct3_i) > 1) &&
                   ((EM_addr_i % f_size(EM_funct3_i)) != 0);
  assign exp_mask = (EM_isStore_i && !EM_nop_i && !M_stall_i && !exp_mis && f_size(EM_funct3_i) != 0)
                    ? 4'(((32'd1 << f_size(EM_funct3_i)) - 32'd1) << (EM_addr_i % 4)) : 4'b0000;

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      m_pc <= 32'd0; m_instr <= NOP; m_nop <= 1'b1; m_wb <= 1'b0; m_rd <= 5'd0; m_data <= 32'd0;
      m_cycle <= 64'd0; m_instret <= 64'd0;
    end else begin
      m_cycle   <= cyc_now + 64'd1;
      m_instret <= m_instret + ((!M_stall_i && !EM_nop_i && !W_flush_i) ? 64'd1 : 64'd0);
      m_pc      <= M_stall_i ? m_pc   : EM_PC_i;
      m_rd      <= M_stall_i ? m_rd   : EM_rdId_i;
      m_data    <= M_stall_i ? m_data : exp_wb;
      m_instr   <= W_flush_i ? NOP  : (M_stall_i ? m_instr : EM_instr_i);
      m_nop     <= W_flush_i ? 1'b1 : (M_stall_i ? m_nop   : EM_nop_i);
      m_wb      <= W_flush_i ? 1'b0 : (M_stall_i ? m_wb    : (EM_wbEnable_i && !EM_nop_i));
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  always @(negedge clk_i) begin
    #1;
    check("mw_pc", MW_PC_o, m_pc);
    check("mw_instr", MW_instr_o, m_instr);
    check("mw_nop", MW_nop_o, m_nop);
    check("mw_wben", MW_wbEnable_o, m_wb);
    check("mw_rd", MW_rdId_o, m_rd);
    check("mw_data", MW_wbData_o, m_data);
    check("misaligned", misaligned_o, exp_mis);
    check("wmask", DMemWMask_o, exp_mask);
    check("waddr", DMemWAddr_o, EM_addr_i & 32'hFFFFFFFC);
    if (EM_isStore_i && f_size(EM_funct3_i) != 0)
      check("wdata", DMemWData_o, f_sdata(EM_funct3_i, EM_rs2_i));
  end

  // ---------------- stimulus ----------------
  task automatic set_idle();
    M_stall_i = 1'b0; W_flush_i = 1'b0; EM_nop_i = 1'b1; EM_isLoad_i = 1'b0;
    EM_isStore_i = 1'b0; EM_isCSR_i = 1'b0; EM_wbEnable_i = 1'b0;
    EM_PC_i = 32'd0; EM_instr_i = NOP; EM_rs2_i = 32'd0; EM_Eresult_i = 32'd0;
    EM_addr_i = 32'd0; EM_Mdata_i = 32'd0; EM_rdId_i = 5'd0; EM_csrId_i = 12'd0;
    EM_funct3_i = 3'd0;
  endtask

  task automatic step();
    @(negedge clk_i);
    #2;
  endtask

  task automatic set_load(input logic [2:0] f3, input logic [1:0] lo);
    set_idle(); EM_nop_i = 1'b0; EM_isLoad_i = 1'b1; EM_wbEnable_i = 1'b1; EM_rdId_i = 5'd7;
    EM_Mdata_i = 32'h80FF7F01; EM_funct3_i = f3; EM_addr_i = {30'h00000800, lo};
  endtask

  task automatic set_csr(input logic [11:0] id);
    set_idle(); EM_nop_i = 1'b0; EM_isCSR_i = 1'b1; EM_wbEnable_i = 1'b1; EM_rdId_i = 5'd3;
    EM_funct3_i = 3'd2; EM_csrId_i = id;
  endtask

  logic [2:0]  load_f3 [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd7};
  logic [11:0] csr_ids [7] = '{12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hC01, 12'hC81, 12'hB00};

  initial begin
    set_idle();
    reset_i = 1'b1;
    repeat (3) step();
    check("rst_nop", MW_nop_o, 1'b1);
    check("rst_instr", MW_instr_o, NOP);
    check("rst_wben", MW_wbEnable_o, 1'b0);
    check("rst_pc_rd_data", {MW_PC_o, MW_wbData_o}, 64'd0);
    check("rst_rd", MW_rdId_o, 5'd0);
    reset_i = 1'b0;

    // SB to 0x1002
    step();
    set_idle(); EM_nop_i = 1'b0; EM_isStore_i = 1'b1; EM_funct3_i = 3'd0;
    EM_rs2_i = 32'h000000AB; EM_addr_i = 32'h00001002; EM_PC_i = 32'h100;
    #1;
    check("sb_addr", DMemWAddr_o, 32'h00001000);
    check("sb_data", DMemWData_o, 32'hABABABAB);
    check("sb_mask", DMemWMask_o, 4'b0100);
    check("sb_mis", misaligned_o, 1'b0);
    M_stall_i = 1'b1;
    #1;
    check("sb_stall_mask", DMemWMask_o, 4'b0000);

    // Load extraction from 0x80FF7F01
    step(); set_load(3'd0, 2'd2);
    step(); check("lb", MW_wbData_o, 32'hFFFFFFFF); set_load(3'd4, 2'd3);
    step(); check("lbu", MW_wbData_o, 32'h00000080); set_load(3'd1, 2'd2);
    step(); check("lh", MW_wbData_o, 32'hFFFF80FF); set_load(3'd5, 2'd0);
    step(); check("lhu", MW_wbData_o, 32'h00007F01);

    // Misaligned stores
    set_idle(); EM_nop_i = 1'b0; EM_isStore_i = 1'b1; EM_funct3_i = 3'd2; EM_addr_i = 32'h00001006;
    #1;
    check("sw_mis", misaligned_o, 1'b1);
    check("sw_mis_mask", DMemWMask_o, 4'b0000);
    EM_funct3_i = 3'd1; EM_addr_i = 32'h00001001;
    #1;
    check("sh_mis", misaligned_o, 1'b1);
    check("sh_mis_mask", DMemWMask_o, 4'b0000);

    // Stall holds MW, then flush under stall
    step(); set_idle(); EM_nop_i = 1'b0; EM_wbEnable_i = 1'b1; EM_rdId_i = 5'd5; EM_Eresult_i = 32'h1234;
    step(); set_idle(); EM_nop_i = 1'b0; EM_wbEnable_i = 1'b1; EM_rdId_i = 5'd9;
    EM_Eresult_i = 32'hDEAD; M_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_rd", MW_rdId_o, 5'd5);
      check("stall_data", MW_wbData_o, 32'h1234);
    end
    W_flush_i = 1'b1;
    step();
    check("flush_nop", MW_nop_o, 1'b1);
    check("flush_wben", MW_wbEnable_o, 1'b0);
    check("flush_rd_held", MW_rdId_o, 5'd5);
    set_csr(12'hC02);

    // Cycle counter carry across the 32-bit boundary
    @(negedge clk_i);
    set_idle();
    force dut.cycle_r = 64'h00000000_FFFFFFFF;
    preload = 1'b1;
    #2 release dut.cycle_r;
    @(negedge clk_i);
    preload = 1'b0;
    set_csr(12'hC00);
    step(); check("csr_c00", MW_wbData_o, 32'h00000000); set_csr(12'hC80);
    step(); check("csr_c80", MW_wbData_o, 32'h00000001); set_csr(12'hC01);
    step(); check("csr_c01", MW_wbData_o, 32'h00000000);

    // instret: 10 retired among 5 bubbles
    reset_i = 1'b1; set_idle();
    step(); reset_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(); set_idle();
      if (i % 3 != 2) begin
        EM_nop_i = 1'b0; EM_wbEnable_i = 1'b1; EM_rdId_i = 5'(i + 1); EM_Eresult_i = 32'(i);
      end
    end
    step(); set_csr(12'hC02);
    step(); check("instret_10", MW_wbData_o, 32'd10);
    set_idle(); EM_nop_i = 1'b0; EM_wbEnable_i = 1'b1; EM_rdId_i = 5'd12; EM_Eresult_i = 32'h55;
    step();
    #1 reset_i = 1'b1;
    #1;
    check("midrst_nop", MW_nop_o, 1'b1);
    check("midrst_instr", MW_instr_o, NOP);
    check("midrst_wben", MW_wbEnable_o, 1'b0);
    check("midrst_rd", MW_rdId_o, 5'd0);
    check("midrst_pc_data", {MW_PC_o, MW_wbData_o}, 64'd0);
    @(negedge clk_i); reset_i = 1'b0; set_csr(12'hC02);
    step(); check("rst_instret", MW_wbData_o, 32'd0); set_csr(12'hC00);
    step(); check("rst_cycle", MW_wbData_o, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int k;
      step();
      set_idle();
      reset_i       = ($urandom_range(0, 199) == 0);
      EM_nop_i      = ($urandom_range(0, 4) == 0);
      M_stall_i     = ($urandom_range(0, 3) == 0);
      W_flush_i     = ($urandom_range(0, 9) == 0);
      EM_PC_i       = $urandom; EM_instr_i = $urandom; EM_rdId_i = 5'($urandom);
      EM_wbEnable_i = (EM_rdId_i != 5'd0);
      EM_Eresult_i  = $urandom; EM_addr_i = $urandom; EM_rs2_i = $urandom;
      EM_Mdata_i    = $urandom; EM_csrId_i = 12'($urandom);
      EM_funct3_i   = 3'($urandom);
      k = $urandom_range(0, 9);
      if (k < 3) begin
        EM_isLoad_i = 1'b1; EM_funct3_i = load_f3[$urandom_range(0, 6)];
      end else if (k < 5) begin
        EM_isStore_i = 1'b1; EM_funct3_i = 3'($urandom_range(0, 2)); EM_wbEnable_i = 1'b0;
      end else if (k < 7) begin
        EM_isCSR_i = 1'b1; EM_funct3_i = 3'd2; EM_csrId_i = csr_ids[$urandom_range(0, 6)];
      end
    end
    reset_i = 1'b0;
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
